// File: rtl/instr_encoder.sv
// RV32I instruction encoder and instruction-memory loader: packs decoded fields
// into 32-bit words and writes them to consecutive instruction-memory addresses.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {S_IDLE, S_ENC, S_WRITE, S_DONE, S_ERROR} state_e;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_LW    = 4'd1,
    OP_SW    = 4'd2,
    OP_ADDI  = 4'd3,
    OP_AUIPC = 4'd4,
    OP_JAL   = 4'd5,
    OP_BEQ   = 4'd6,
    OP_BLT   = 4'd7
  } op_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OP   = 2'b01;
  localparam logic [1:0] ERR_IMM  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [31:0]       imm_q;
  logic              last_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q, err_q;
  logic [1:0]        err_code_q;
  logic [ADDR_W:0]   count_q;

  logic [31:0]       wdata_d;
  logic [1:0]        code_d;
  logic              imm12_ok, imm13_ok, imm21_ok;

  // A signed value fits in N bits when all bits from N-1 upward are equal.
  assign imm12_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign imm13_ok = ((&imm_q[31:12]) | ~(|imm_q[31:12])) & ~imm_q[0];
  assign imm21_ok = ((&imm_q[31:20]) | ~(|imm_q[31:20])) & ~imm_q[0];

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    wdata_d = '0;
    code_d  = ERR_NONE;
    case (op_q)
      OP_ADD:   wdata_d = {7'b0, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
      OP_LW:    if (imm12_ok) wdata_d = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
                else          code_d  = ERR_IMM;
      OP_SW:    if (imm12_ok) wdata_d = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
                else          code_d  = ERR_IMM;
      OP_ADDI:  if (imm12_ok) wdata_d = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011};
                else          code_d  = ERR_IMM;
      OP_AUIPC: if (imm_q[11:0] == 12'd0) wdata_d = {imm_q[31:12], rd_q, 7'b0010111};
                else                      code_d  = ERR_IMM;
      OP_JAL:   if (imm21_ok) wdata_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
                else          code_d  = ERR_IMM;
      OP_BEQ, OP_BLT:
                if (imm13_ok) wdata_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, op_q[0], 2'b00,
                                         imm_q[4:1], imm_q[11], 7'b1100011};
                else          code_d  = ERR_IMM;
      default:  code_d = ERR_OP;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      last_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      count_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q    <= in_op;
          rd_q    <= in_rd;
          rs1_q   <= in_rs1;
          rs2_q   <= in_rs2;
          imm_q   <= in_imm;
          last_q  <= in_last;
          state_q <= S_ENC;
        end
        S_ENC: if (code_d != ERR_NONE) begin
          err_q      <= 1'b1;
          err_code_q <= code_d;
          state_q    <= S_ERROR;
        end else begin
          mem_wdata_q <= wdata_d;
          mem_we_q    <= 1'b1;
          state_q     <= S_WRITE;
        end
        S_WRITE: if (mem_ready) begin
          mem_we_q   <= 1'b0;
          count_q    <= count_q + CNT_ONE;
          mem_addr_q <= mem_addr_q + ADDR_ONE;
          // Comparing the pre-increment count avoids waiting a cycle for the overflow.
          if (last_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (count_q == CNT_LAST) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_OVF;
            state_q    <= S_ERROR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = !reset && (state_q == S_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a stimulus thread queues expected writes from
// a field-level reference model; a monitor thread pops and compares each write.
module tb_instr_encoder;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          in_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic          done, err;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .done(done), .err(err),
    .err_code(err_code), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            model_count;
  logic [AW-1:0] model_addr;
  logic          exp_done, exp_err;
  logic [1:0]    exp_code;
  int            ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  logic          mon_prev_we = 1'b0;
  wr_t           mon_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: field placement by shifts and masks on integers.
  function automatic void ref_model(input int op, input int rd, input int rs1, input int rs2,
                                    input int imm, output logic [31:0] w, output logic [1:0] code);
    logic [31:0] u;
    u = imm;
    w = 0;
    code = 0;
    case (op)
      0: w = 32'h33 | (rd << 7) | (rs1 << 15) | (rs2 << 20);
      1, 3: if (imm < -2048 || imm > 2047) code = 2;
            else w = ((op == 1) ? (32'h03 | (2 << 12)) : 32'h13) | (rd << 7) | (rs1 << 15)
                     | ((u & 32'hfff) << 20);
      2: if (imm < -2048 || imm > 2047) code = 2;
         else w = 32'h23 | ((u & 31) << 7) | (2 << 12) | (rs1 << 15) | (rs2 << 20)
                  | (((u >> 5) & 127) << 25);
      4: if ((u & 32'hfff) != 0) code = 2;
         else w = 32'h17 | (rd << 7) | (u & 32'hfffff000);
      5: if (imm % 2 != 0 || imm < -1048576 || imm > 1048574) code = 2;
         else w = 32'h6f | (rd << 7) | (((u >> 12) & 255) << 12) | (((u >> 11) & 1) << 20)
                  | (((u >> 1) & 1023) << 21) | (((u >> 20) & 1) << 31);
      6, 7: if (imm % 2 != 0 || imm < -4096 || imm > 4094) code = 2;
            else w = 32'h63 | (((op == 7) ? 4 : 0) << 12) | (((u >> 11) & 1) << 7)
                     | (((u >> 1) & 15) << 8) | (rs1 << 15) | (rs2 << 20)
                     | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
      default: code = 1;
    endcase
  endfunction

  // Monitor: a rising mem_we is a new write; a held mem_we must keep addr/data stable.
  initial begin
    forever begin
      @(negedge clock);
      if (mem_we && !mon_prev_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=0x%0h data=0x%08h required=no write", mem_addr, mem_wdata);
        end else begin
          mon_cur = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_cur.addr));
          check("wr_data", mem_wdata, mon_cur.data);
        end
      end else if (mem_we && mon_prev_we) begin
        check("hold_addr", 32'(mem_addr), 32'(mon_cur.addr));
        check("hold_data", mem_wdata, mon_cur.data);
      end
      mon_prev_we = mem_we;
    end
  end

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ($urandom_range(0, 3) != 0);
        default: mem_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_flags", {28'd0, done, err, err_code}, 0);
    check("rst_count", 32'(count), 0);
    reset = 1'b0;
    model_count = 0;
    model_addr = '0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    exp_code = 2'b00;
  endtask

  task automatic expect_bundle(input int op, input int rd, input int rs1, input int rs2, input int imm,
                               input logic use_gold, input logic [31:0] gold, output logic [1:0] code);
    logic [31:0] w;
    ref_model(op, rd, rs1, rs2, imm, w, code);
    if (use_gold) w = gold;
    if (code == 2'b00) exp_q.push_back('{addr: model_addr, data: w});
  endtask

  task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int imm,
                       input logic last);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("in_ready_before_issue", 32'(in_ready), 1);
    in_op = 4'(op);
    in_rd = 5'(rd);
    in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2);
    in_imm = imm;
    in_last = last;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic settle(input logic [1:0] code, input logic last);
    int n;
    n = 0;
    @(negedge clock);
    while (!(in_ready || done || err) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (code != 2'b00) begin
      exp_err = 1'b1;
      exp_code = code;
    end else begin
      model_count++;
      model_addr++;
      if (last) exp_done = 1'b1;
      else if (model_count == (1 << AW)) begin
        exp_err = 1'b1;
        exp_code = 2'b11;
      end
    end
    check("count", 32'(count), model_count);
    check("done", 32'(done), 32'(exp_done));
    check("err", 32'(err), 32'(exp_err));
    check("err_code", 32'(err_code), 32'(exp_code));
    check("in_ready_after", 32'(in_ready), 32'(!(exp_done || exp_err)));
    check("mem_we_idle", 32'(mem_we), 0);
  endtask

  task automatic run_bundle(input int op, input int rd, input int rs1, input int rs2, input int imm,
                            input logic last, input logic use_gold, input logic [31:0] gold);
    logic [1:0] code;
    expect_bundle(op, rd, rs1, rs2, imm, use_gold, gold, code);
    issue(op, rd, rs1, rs2, imm, last);
    settle(code, last);
  endtask

  task automatic rand_fields(output int op, output int rd, output int rs1, output int rs2, output int imm);
    op = int'($urandom_range(0, 7));
    rd = int'($urandom_range(0, 31));
    rs1 = int'($urandom_range(0, 31));
    rs2 = int'($urandom_range(0, 31));
    case (op)
      1, 2, 3: imm = int'($urandom_range(0, 4095)) - 2048;
      4:       imm = int'($urandom & 32'hfffff000);
      5:       imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      6, 7:    imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
      default: imm = int'($urandom);
    endcase
    if ($urandom_range(0, 11) == 0) begin
      if ($urandom_range(0, 1) == 1) op = int'($urandom_range(8, 15));
      else imm = int'($urandom);
    end
  endtask

  int          bnd_ok_op[9]  = '{3, 3, 1, 2, 6, 7, 5, 5, 4};
  int          bnd_ok_imm[9] = '{2047, -2048, -2048, 2047, 4094, -4096, 1048574, -1048576, 32'hfffff000};
  int          bnd_bad_op[7]  = '{3, 2, 6, 7, 5, 5, 4};
  int          bnd_bad_imm[7] = '{2048, -2049, 4096, -4098, 1048576, -3, 32'h800};
  logic [31:0] prog_gold[5] = '{32'h004000EF, 32'h00512003, 32'h000122A3, 32'h00104263, 32'h00100263};
  int          prog_op[5]   = '{5, 1, 2, 7, 6};
  int          prog_rd[5]   = '{1, 0, 0, 0, 0};
  int          prog_rs1[5]  = '{0, 2, 2, 0, 0};
  int          prog_rs2[5]  = '{0, 0, 0, 1, 1};
  int          prog_imm[5]  = '{4, 5, 5, 4, 4};

  initial begin
    logic [1:0] code;
    int op, rd, rs1, rs2, imm;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
    do_reset();

    // Single ADDI: write appears two cycles after acceptance, for one cycle.
    expect_bundle(3, 0, 1, 0, 4, 1'b1, 32'h00408013, code);
    issue(3, 0, 1, 0, 4, 1'b0);
    @(negedge clock); check("lat_enc_we", 32'(mem_we), 0);
    @(negedge clock); check("lat_write_we", 32'(mem_we), 1);
    @(negedge clock); check("lat_drop_we", 32'(mem_we), 0);
    settle(code, 1'b0);

    // Short program ending in DONE, then bundles must be ignored.
    do_reset();
    for (int i = 0; i < 5; i++)
      run_bundle(prog_op[i], prog_rd[i], prog_rs1[i], prog_rs2[i], prog_imm[i], i == 4, 1'b1, prog_gold[i]);
    in_valid = 1'b1;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    check("done_hold_count", 32'(count), 5);
    check("done_hold_ready", 32'(in_ready), 0);

    // Stalled ADD with in_valid held high during the stall.
    do_reset();
    ready_mode = 2;
    @(negedge clock);
    expect_bundle(0, 0, 1, 2, 0, 1'b1, 32'h00208033, code);
    issue(0, 0, 1, 2, 0, 1'b0);
    in_valid = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_we", 32'(mem_we), 1);
      check("stall_ready", 32'(in_ready), 0);
      check("stall_count", 32'(count), 0);
    end
    in_valid = 1'b0;
    ready_mode = 0;
    settle(code, 1'b0);

    // Reset while a write is stalled.
    ready_mode = 2;
    @(negedge clock);
    expect_bundle(3, 5, 6, 0, -7, 1'b0, 32'h0, code);
    issue(3, 5, 6, 0, -7, 1'b0);
    repeat (2) @(negedge clock);
    check("pre_rst_we", 32'(mem_we), 1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_we", 32'(mem_we), 0);
    check("midrst_addr", 32'(mem_addr), 0);
    check("midrst_count", 32'(count), 0);
    check("midrst_ready", 32'(in_ready), 0);
    reset = 1'b0;
    @(negedge clock);
    check("postrst_ready", 32'(in_ready), 1);
    ready_mode = 0;
    do_reset();

    // Error codes and AUIPC.
    run_bundle(6, 0, 1, 2, 3, 1'b0, 1'b0, 32'h0);
    do_reset();
    run_bundle(9, 1, 1, 1, 0, 1'b0, 1'b0, 32'h0);
    do_reset();
    run_bundle(4, 0, 0, 0, 32'h0000A000, 1'b1, 1'b1, 32'h0000A017);

    // Immediate boundaries.
    do_reset();
    for (int i = 0; i < 9; i++)
      run_bundle(bnd_ok_op[i], 3, 4, 5, bnd_ok_imm[i], 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      do_reset();
      run_bundle(bnd_bad_op[i], 3, 4, 5, bnd_bad_imm[i], 1'b0, 1'b0, 32'h0);
    end

    // Randomized programs with random memory back-pressure.
    ready_mode = 1;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int j = 0; j < 25 && !exp_done && !exp_err; j++) begin
        rand_fields(op, rd, rs1, rs2, imm);
        run_bundle(op, rd, rs1, rs2, imm, $urandom_range(0, 9) == 0, 1'b0, 32'h0);
      end
    end

    // Fill the whole memory: the last slot's write triggers the overflow error.
    do_reset();
    for (int i = 0; i < (1 << AW); i++)
      run_bundle(3, i % 32, (i * 7) % 32, 0, int'($urandom_range(0, 4095)) - 2048, 1'b0, 1'b0, 32'h0);
    in_valid = 1'b1;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    check("ovf_code", 32'(err_code), 3);
    check("ovf_count", 32'(count), 1 << AW);
    check("ovf_ready", 32'(in_ready), 0);
    check("ovf_done", 32'(done), 0);
    ready_mode = 0;

    repeat (3) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

RV32I instruction encoder and instruction-memory loader: accepts decoded instruction fields (operation class, register numbers, signed immediate) over a valid/ready handshake, packs them into 32-bit RV32I words, and writes them to consecutive instruction-memory words. It is the inverse of the CPU's main decoder and supports the same instruction subset. It sits between the bench/boot sequencer and the instruction memory write port, and generates programs for CPU bring-up.

## Interface
- ADDR_W, 8, word-address width of instruction memory; capacity 2^ADDR_W words
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_op  in  4  0 ADD, 1 LW, 2 SW, 3 ADDI, 4 AUIPC, 5 JAL, 6 BEQ, 7 BLT, 8-15 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register numbers; unused fields ignored
- in_imm  in  32  two's-complement byte immediate (AUIPC: full 32-bit value, upper 20 bits used)
- in_last  in  1  bundle is the final instruction of the program
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write this cycle
- done  out  1  sticky; program fully written
- err  out  1  sticky; loading aborted
- err_code  out  2  01 illegal op, 10 immediate range/alignment, 11 address overflow
- count  out  ADDR_W+1  instructions written

## Operation
- FSM states: IDLE, ENC, WRITE, DONE, ERROR.
- IDLE: in_ready=1. On in_valid: capture all in_* fields, go to ENC.
- ENC (one cycle): encode and check. Illegal op -> ERROR, err_code=01. Immediate violation -> ERROR, err_code=10. Otherwise register mem_wdata, assert mem_we, go to WRITE.
- Encodings (standard RV32I):
  - ADD: funct7=0, rs2, rs1, f3=000, rd, 0110011.
  - LW: imm[11:0], rs1, 010, rd, 0000011.
  - SW: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
  - ADDI: imm[11:0], rs1, 000, rd, 0010011.
  - AUIPC: imm[31:12], rd, 0010111.
  - JAL: imm[20|10:1|11|19:12], rd, 1101111.
  - BEQ/BLT: imm[12|10:5], rs2, rs1, f3 (000/100), imm[4:1|11], 1100011.
- Immediate rules:
  - LW/SW/ADDI: range -2048..2047.
  - AUIPC: in_imm[11:0] must be 0.
  - BEQ/BLT: even, range -4096..4094.
  - JAL: even, range -1048576..1048574.
  - ADD: in_imm ignored.
- WRITE: hold mem_we, mem_addr and mem_wdata stable until mem_ready=1. On acceptance: mem_we drops next cycle, count increments, mem_addr increments. Then:
  - captured last=1 -> DONE.
  - Else, if count now equals 2^ADDR_W -> ERROR, err_code=11 (mem_addr wraps to 0 but is unused).
  - Else -> IDLE.
- DONE: done=1, in_ready=0 until reset.
- ERROR: err=1, in_ready=0, mem_we=0 until reset. No write is issued for the faulting bundle.
- rd=x0 is encoded normally; it is not an error.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, err_code=00, count=0, state=IDLE.
- in_ready=0 during any cycle with reset=1; otherwise in_ready = (state==IDLE), combinational from state.
- Latency: bundle accepted on edge N; mem_we=1 with valid data in the cycle after edge N+1. With mem_ready tied high, throughput is one instruction per 3 cycles.
- mem_ready is sampled only while mem_we=1; mem_ready outside WRITE is ignored.
- in_valid while in_ready=0 is ignored; no bundle is queued.
- Reset mid-WRITE: on the next edge mem_we=0 and all outputs return to reset values. The partial write is abandoned.
- done and err are never both 1.

## Test plan
- Reset, then ADDI rd=0 rs1=1 imm=4 with mem_ready=1 -> mem_we for one cycle, 2 cycles after acceptance, addr 0, wdata 0x00408013; count=1.
- Program of JAL rd=1 imm=4; LW rd=0 rs1=2 imm=5; SW rs1=2 rs2=0 imm=5; BLT rs1=0 rs2=1 imm=4; BEQ rs1=0 rs2=1 imm=4 (in_last) -> wdata 0x004000EF, 0x00512003, 0x000122A3, 0x00104263, 0x00100263 at addr 0..4; done=1, count=5, in_ready=0.
- ADD rd=0 rs1=1 rs2=2 with mem_ready low for 3 cycles -> mem_we, addr and wdata 0x00208033 stable for 4 cycles; in_ready=0 throughout; count increments only after acceptance.
- BEQ imm=3 -> err=1, err_code=10, no mem_we. After reset, op=9 -> err_code=01. AUIPC imm=0x0000A000 rd=0 -> 0x0000A017.
- ADDR_W=2, five ADDI bundles without last -> four writes (addr 0..3), then err=1, err_code=11, count=4, fifth bundle not accepted.
- Assert reset during WRITE with mem_ready low -> next cycle mem_we=0, mem_addr=0, count=0, in_ready=1 after reset deasserts.
